flux_rr_scheduler: RTL and testbench

//  Shares one multi-flux actor (e.g. multiplier_9) among FLUX tagged dataflow streams.

---
 rtl/flux_sched_pkg.sv | 32 +++
 rtl/flux_rr_scheduler_rr_find_first.sv | 34 +++
 rtl/flux_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_flux_rr_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flux_sched_pkg.sv
// flux_sched_pkg
//   Shared helpers for the flux round-robin scheduler.
//   - tag_width(flux): index width needed to name one of 'flux' streams.
//   - tag_t: widest tag type the helpers work with (up to MAX_FLUX streams).
//   - onehot2bin(): one-hot grant vector to binary index.
package flux_sched_pkg;

  // Upper bound on the number of streams the helpers can encode.
  localparam int MAX_FLUX = 64;

  function automatic int tag_width(input int flux);
    return $clog2(flux);
  endfunction

  localparam int MAX_TAG_WIDTH = tag_width(MAX_FLUX);

  typedef logic [MAX_TAG_WIDTH-1:0] tag_t;

  // OR-reduction encoder: for a one-hot input only one term contributes,
  // and an all-zero input yields index 0.
  function automatic tag_t onehot2bin(input logic [MAX_FLUX-1:0] onehot);
    tag_t idx;
    idx = '0;
    for (int i = 0; i < MAX_FLUX; i++) begin
      if (onehot[i]) begin
        idx = idx | tag_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/flux_rr_scheduler_rr_find_first.sv
// rr_find_first
//   Rotating priority encoder: finds the first set bit of 'vec' starting at
//   index 'start' and wrapping around, so 'start-1' is the last candidate.
// Ports:
//   vec    in   N    candidate bits
//   start  in   IW   index searched first
//   found  out  1    some bit of vec is set
//   index  out  IW   position of the first set bit in rotated order, 0 if none
module rr_find_first #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] pos;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(start) + k) % N);
      if (!found && vec[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// flux_rr_scheduler
//   Shares one multi-flux actor among FLUX tagged streams with sticky
//   round-robin arbitration, a per-owner burst limit, a block lock and a
//   runtime enable mask. Grant is combinational from the actor's eligibility.
// Ports:
//   clk           in   1          rising-edge clock
//   rst           in   1          synchronous active-high reset
//   req           in   FLUX       per-flux eligibility
//   done          in   1          granted flux completes a transfer this cycle
//   hold          in   1          with done: keep the lock on the served flux
//   cfg_we        in   1          load the enable mask
//   cfg_mask      in   FLUX       new enable mask, 1 = may be granted
//   grant         out  FLUX       one-hot grant
//   tag           out  TAG_WIDTH  binary index of grant, 0 when nothing granted
//   grant_valid   out  1          some flux granted
//   locked        out  1          registered lock state
//   protocol_err  out  1          sticky: done seen with nothing granted
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter  int FLUX      = 2,
  parameter  int MAX_BURST = 4,
  localparam int TAG_WIDTH = tag_width(FLUX),
  localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic                 done,
  input  logic                 hold,
  input  logic                 cfg_we,
  input  logic [FLUX-1:0]      cfg_mask,
  output logic [FLUX-1:0]      grant,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 grant_valid,
  output logic                 locked,
  output logic                 protocol_err
);

  logic [TAG_WIDTH-1:0] owner;
  logic [BURST_W-1:0]   burst_cnt;
  logic [FLUX-1:0]      mask;

  logic [FLUX-1:0]      req_m;
  logic [FLUX-1:0]      others;
  logic [TAG_WIDTH-1:0] start_idx;
  logic                 found;
  logic [TAG_WIDTH-1:0] found_idx;
  logic                 sel_valid;
  logic [TAG_WIDTH-1:0] sel_idx;
  logic [MAX_FLUX-1:0]  grant_ext;

  logic [TAG_WIDTH-1:0] owner_upd;
  logic [BURST_W-1:0]   burst_upd;
  logic                 lock_upd;

  assign req_m = req & mask;

  // The rotating search starts just after the owner, so the owner itself is
  // naturally the last candidate.
  always_comb begin
    start_idx = (owner == TAG_WIDTH'(FLUX - 1)) ? '0 : owner + TAG_WIDTH'(1);
  end

  rr_find_first #(.N(FLUX)) u_find (
    .vec   (req_m),
    .start (start_idx),
    .found (found),
    .index (found_idx)
  );

  // Stay with the owner while locked, or while its burst budget lasts, or
  // when nobody else is waiting; otherwise take the rotated pick.
  always_comb begin
    others        = req_m;
    others[owner] = 1'b0;
    sel_valid     = 1'b0;
    sel_idx       = owner;
    if (rst) begin
      sel_valid = 1'b0;
    end else if (locked) begin
      sel_valid = req_m[owner];
    end else if (req_m[owner] &&
                 ((burst_cnt < BURST_W'(MAX_BURST)) || (others == '0))) begin
      sel_valid = 1'b1;
    end else if (found) begin
      sel_valid = 1'b1;
      sel_idx   = found_idx;
    end
  end

  always_comb begin
    grant = '0;
    if (sel_valid) begin
      grant[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_ext             = '0;
    grant_ext[FLUX-1:0]   = grant;
    tag                   = TAG_WIDTH'(onehot2bin(grant_ext));
    grant_valid           = |grant;
  end

  // Next owner/burst/lock. The mask check looks at the owner after this
  // edge's transfer, so a mask write beats a hold on the flux just served.
  always_comb begin
    owner_upd = owner;
    burst_upd = burst_cnt;
    lock_upd  = locked;
    if (done && grant_valid) begin
      if (tag == owner) begin
        if (burst_cnt < BURST_W'(MAX_BURST)) begin
          burst_upd = burst_cnt + BURST_W'(1);
        end
      end else begin
        owner_upd = tag;
        burst_upd = BURST_W'(1);
      end
      lock_upd = hold;
    end
    if (cfg_we && !cfg_mask[owner_upd]) begin
      lock_upd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= '0;
      burst_cnt    <= '0;
      locked       <= 1'b0;
      mask         <= '1;
      protocol_err <= 1'b0;
    end else begin
      owner     <= owner_upd;
      burst_cnt <= burst_upd;
      locked    <= lock_upd;
      if (cfg_we) begin
        mask <= cfg_mask;
      end
      if (done && !grant_valid) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// tb_flux_rr_scheduler
//   Directed scenarios followed by random traffic, each cycle compared with a
//   behavioural scheduler model kept here.
module tb_flux_rr_scheduler;

  localparam int FLUX      = 4;
  localparam int MAX_BURST = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       hold;
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic [3:0] grant;
  logic [1:0] tag;
  logic       grant_valid;
  logic       locked;
  logic       protocol_err;

  int testCount = 0;
  int failCount = 0;

  // Model state
  int         mOwner;
  int         mCnt;
  bit         mLocked;
  bit         mPerr;
  logic [3:0] mMask;

  // Model expectations for the current cycle
  bit         eValid;
  int         eTag;
  logic [3:0] eGrant;

  flux_rr_scheduler #(.FLUX(FLUX), .MAX_BURST(MAX_BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done         (done),
    .hold         (hold),
    .cfg_we       (cfg_we),
    .cfg_mask     (cfg_mask),
    .grant        (grant),
    .tag          (tag),
    .grant_valid  (grant_valid),
    .locked       (locked),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOwner  = 0;
    mCnt    = 0;
    mLocked = 0;
    mPerr   = 0;
    mMask   = 4'hF;
  endtask

  // Who should be served, from the rules: stay, rotate, or nothing.
  task automatic predict();
    logic [3:0] rm;
    int nOthers;
    eValid = 0;
    eTag   = 0;
    rm     = req & mMask;
    if (!rst) begin
      nOthers = $countones(rm) - int'(rm[mOwner]);
      if (mLocked) begin
        if (rm[mOwner]) begin eValid = 1; eTag = mOwner; end
      end else if (rm[mOwner] && (mCnt < MAX_BURST || nOthers == 0)) begin
        eValid = 1;
        eTag   = mOwner;
      end else begin
        for (int d = 1; d <= FLUX; d++) begin
          if (!eValid && rm[(mOwner + d) % FLUX]) begin
            eValid = 1;
            eTag   = (mOwner + d) % FLUX;
          end
        end
      end
    end
    eGrant = eValid ? (4'b0001 << eTag) : 4'b0000;
  endtask

  task automatic updateModel();
    if (rst) begin
      modelReset();
    end else begin
      if (done && eValid) begin
        if (eTag == mOwner) begin
          mCnt = (mCnt + 1 > MAX_BURST) ? MAX_BURST : mCnt + 1;
        end else begin
          mOwner = eTag;
          mCnt   = 1;
        end
        mLocked = hold;
      end
      if (done && !eValid) mPerr = 1;
      if (cfg_we) begin
        if (!cfg_mask[mOwner]) mLocked = 0;
        mMask = cfg_mask;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic d,
                               input logic h, input logic we, input logic [3:0] m);
    @(negedge clk);
    rst      = r;
    req      = rq;
    done     = d;
    hold     = h;
    cfg_we   = we;
    cfg_mask = m;
    #1;
  endtask

  task automatic checkOutput();
    predict();
    check("grant_valid", 32'(grant_valid), 32'(eValid));
    check("tag", 32'(tag), 32'(eTag));
    check("grant", 32'(grant), 32'(eGrant));
    check("locked", 32'(locked), 32'(mLocked));
    check("protocol_err", 32'(protocol_err), 32'(mPerr));
    updateModel();
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic d,
                      input logic h, input logic we, input logic [3:0] m);
    applyStimulus(r, rq, d, h, we, m);
    checkOutput();
  endtask

  initial begin
    int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    rst = 1; req = '0; done = 0; hold = 0; cfg_we = 0; cfg_mask = '0;
    modelReset();
    repeat (2) @(posedge clk);

    // 1. Reset behaviour
    applyStimulus(1, 4'hF, 1, 1, 0, 4'h0);
    check("rst_grant", 32'(grant), 32'h0);
    checkOutput();
    applyStimulus(0, 4'h0, 0, 0, 0, 4'h0);
    check("idle_valid", 32'(grant_valid), 32'h0);
    check("idle_locked", 32'(locked), 32'h0);
    checkOutput();

    // 2. Fairness with everyone requesting
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 4'hF, 1, 0, 0, 4'h0);
      check("fair_seq", 32'(tag), 32'(seq[i]));
      checkOutput();
    end

    // 3. Sole requester, then a second requester after saturation
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 4'b0100, 1, 0, 0, 4'h0);
      check("sole_tag", 32'(tag), 32'd2);
      checkOutput();
    end
    applyStimulus(0, 4'b0101, 1, 0, 0, 4'h0);
    check("sole_then_0", 32'(tag), 32'd0);
    checkOutput();

    // 4. Lock past the burst limit, drop, release
    applyStimulus(0, 4'b0010, 1, 1, 0, 4'h0);
    check("lock_take", 32'(tag), 32'd1);
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4'b1011, 1, 1, 0, 4'h0);
      check("lock_stay", 32'(tag), 32'd1);
      checkOutput();
    end
    applyStimulus(0, 4'b1001, 0, 0, 0, 4'h0);
    check("lock_norq", 32'(grant_valid), 32'h0);
    checkOutput();
    step(0, 4'b1011, 1, 0, 0, 4'h0);
    applyStimulus(0, 4'b1011, 1, 0, 0, 4'h0);
    check("unlock_next", 32'(tag), 32'd3);
    checkOutput();

    // 5. Mask write clears a lock on a masked owner
    step(0, 4'b0100, 1, 1, 0, 4'h0);
    step(0, 4'b0100, 0, 0, 1, 4'b1011);
    applyStimulus(0, 4'b0100, 0, 0, 0, 4'h0);
    check("mask_unlock", 32'(locked), 32'h0);
    check("mask_block", 32'(grant_valid), 32'h0);
    checkOutput();
    applyStimulus(0, 4'b0110, 0, 0, 0, 4'h0);
    check("mask_tag1", 32'(tag), 32'd1);
    checkOutput();
    step(0, 4'b0000, 0, 0, 1, 4'hF);

    // 6. Protocol error and reset mid-lock
    step(0, 4'b0000, 1, 0, 0, 4'h0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'h0);
    check("perr_set", 32'(protocol_err), 32'h1);
    checkOutput();
    step(0, 4'b0010, 1, 1, 0, 4'h0);
    applyStimulus(0, 4'b0010, 1, 1, 0, 4'h0);
    check("pre_rst_lock", 32'(locked), 32'h1);
    checkOutput();
    step(1, 4'hF, 1, 1, 0, 4'h0);
    applyStimulus(0, 4'hF, 0, 0, 0, 4'h0);
    check("post_rst_lock", 32'(locked), 32'h0);
    check("post_rst_perr", 32'(protocol_err), 32'h0);
    check("post_rst_tag", 32'(tag), 32'd0);
    checkOutput();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 49) == 0),
           4'($urandom),
           logic'($urandom_range(0, 9) < 7),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 9) == 0),
           4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
